tile_result_packer: RTL and testbench

TILE_RESULT_PACKER -- requirements
Module: tile_result_packer

---
 rtl/tile_result_packer.sv | 140 ++++++++++++++
 tb/tb_tile_result_packer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tile_result_packer.sv
// Pairs consecutive 32-bit accumulator results into one NoC flit and queues them in an FWFT FIFO.
// Define TILE_RESULT_PACKER_OVF_CNT_EN to build the saturating overflow counter.
module tile_result_packer #(
  parameter int unsigned NOC_FLIT_W = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NOC_FLIT_W-1:0]         res_flit_in,
  input  logic                          res_valid_in,
  input  logic                          flush,
  output logic [NOC_FLIT_W-1:0]         pkt_flit_out,
  output logic                          pkt_half_out,
  output logic                          pkt_valid_out,
  input  logic                          pkt_ready_in,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_count
);

  localparam int unsigned ResW  = NOC_FLIT_W / 2;
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e                state_q, state_d;
  logic [ResW-1:0]       result_a_q, result_a_d;
  logic [ResW-1:0]       res_lo;
  logic                  push;
  logic [NOC_FLIT_W-1:0] push_flit;
  logic                  push_half;

  // Upper half of the local-port flit carries nothing for this block.
  logic unused_res_hi;
  assign unused_res_hi = ^res_flit_in[NOC_FLIT_W-1:ResW];
  assign res_lo        = res_flit_in[ResW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      result_a_q <= '0;
    end else begin
      state_q    <= state_d;
      result_a_q <= result_a_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    result_a_d = result_a_q;
    push       = 1'b0;
    push_flit  = '0;
    push_half  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (res_valid_in && flush) begin
          push      = 1'b1;
          push_flit = {{ResW{1'b0}}, res_lo};
          push_half = 1'b1;
        end else if (res_valid_in) begin
          result_a_d = res_lo;
          state_d    = StHold;
        end
      end
      StHold: begin
        // A result arriving with flush completes the pair; flush has nothing left to emit.
        if (res_valid_in) begin
          push      = 1'b1;
          push_flit = {res_lo, result_a_q};
          state_d   = StIdle;
        end else if (flush) begin
          push      = 1'b1;
          push_flit = {{ResW{1'b0}}, result_a_q};
          push_half = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic [NOC_FLIT_W:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]     level_q, level_d;
  logic                full, pop, wr_en;
  logic [NOC_FLIT_W:0] head;

  assign full  = (level_q == LvlW'(FIFO_DEPTH));
  assign pop   = (level_q != '0) && pkt_ready_in;
  assign wr_en = push && (!full || pop);

  always_comb begin
    level_d = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !wr_en) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AddrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {push_half, push_flit};
  end

  // Storage is never reset, so gate the head with valid to keep outputs clean out of reset.
  assign head          = mem_q[rd_ptr_q];
  assign pkt_valid_out = (level_q != '0);
  assign pkt_flit_out  = pkt_valid_out ? head[NOC_FLIT_W-1:0] : '0;
  assign pkt_half_out  = pkt_valid_out & head[NOC_FLIT_W];
  assign fifo_level    = level_q;

`ifdef TILE_RESULT_PACKER_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
    end else if (push && full && !pop && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign overflow_count = ovf_cnt_q;
`else
  assign overflow_count = 16'h0;
`endif

endmodule

// File: tb/tb_tile_result_packer.sv
// Randomized self-checking bench for tile_result_packer against a queue-based pairing model.
module tb_tile_result_packer;

  localparam int unsigned W  = 64;
  localparam int unsigned D  = 8;
  localparam int unsigned LW = $clog2(D) + 1;
`ifdef TILE_RESULT_PACKER_OVF_CNT_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  res_flit_in = '0;
  logic          res_valid_in = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  pkt_flit_out;
  logic          pkt_half_out;
  logic          pkt_valid_out;
  logic          pkt_ready_in = 1'b0;
  logic [LW-1:0] fifo_level;
  logic [15:0]   overflow_count;

  tile_result_packer #(
    .NOC_FLIT_W(W),
    .FIFO_DEPTH(D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .res_flit_in   (res_flit_in),
    .res_valid_in  (res_valid_in),
    .flush         (flush),
    .pkt_flit_out  (pkt_flit_out),
    .pkt_half_out  (pkt_half_out),
    .pkt_valid_out (pkt_valid_out),
    .pkt_ready_in  (pkt_ready_in),
    .fifo_level    (fifo_level),
    .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queued flits as {half, flit}, plus the held odd result.
  logic [W:0]  mq[$];
  bit          held;
  logic [31:0] held_val;
  int          ovf_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [W:0] h;
    check("valid", 64'(pkt_valid_out), 64'(mq.size() != 0));
    check("level", 64'(fifo_level), 64'(mq.size()));
    if (mq.size() != 0) begin
      h = mq[0];
      check("flit", pkt_flit_out, h[W-1:0]);
      check("half", 64'(pkt_half_out), 64'(h[W]));
    end else begin
      check("flit_idle", pkt_flit_out, 64'h0);
      check("half_idle", 64'(pkt_half_out), 64'h0);
    end
    check("ovf", 64'(overflow_count), 64'(ovf_exp));
  endtask

  // Called #1 after a rising edge (or during reset release); applies inputs for one cycle.
  task automatic cycle(input bit v, input logic [31:0] lo, input bit fl, input bit rdy);
    bit          do_push;
    bit          half;
    bit          pop;
    bit          full;
    logic [63:0] pf;
    do_push      = 1'b0;
    half         = 1'b0;
    pf           = '0;
    res_valid_in = v;
    res_flit_in  = {$urandom(), lo};
    flush        = fl;
    pkt_ready_in = rdy;
    check_outputs();
    if (v && held) begin
      pf = {lo, held_val}; do_push = 1'b1; held = 1'b0;
    end else if (fl && held) begin
      pf = {32'h0, held_val}; half = 1'b1; do_push = 1'b1; held = 1'b0;
    end else if (v && fl) begin
      pf = {32'h0, lo}; half = 1'b1; do_push = 1'b1;
    end else if (v) begin
      held = 1'b1; held_val = lo;
    end
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == D);
    if (pop) void'(mq.pop_front());
    if (do_push) begin
      if (!full || pop) mq.push_back({half, pf});
      else if (OvfEn && ovf_exp < 65535) ovf_exp++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    mq.delete();
    held    = 1'b0;
    ovf_exp = 0;
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    held    = 1'b0;
    held_val = '0;
    ovf_exp = 0;
    #1;
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two results on consecutive cycles form one full flit.
    cycle(1, 32'h11, 0, 1);
    cycle(1, 32'h22, 0, 1);
    check("s_pair_flit", pkt_flit_out, 64'h00000022_00000011);
    check("s_pair_half", 64'(pkt_half_out), 64'h0);
    cycle(0, 0, 0, 1);

    // Odd result forced out by a later flush.
    cycle(1, 32'hAB, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    check("s_flush_flit", pkt_flit_out, 64'h00000000_000000AB);
    check("s_flush_half", 64'(pkt_half_out), 64'h1);
    cycle(0, 0, 1, 1);
    check("s_flush_noop", 64'(fifo_level), 64'h0);

    // Flush coinciding with a result, in HOLD then in IDLE.
    cycle(1, 32'h5, 0, 0);
    cycle(1, 32'h6, 1, 0);
    check("s_hold_flush", pkt_flit_out, 64'h00000006_00000005);
    check("s_hold_lvl", 64'(fifo_level), 64'h1);
    cycle(1, 32'h7, 1, 0);
    check("s_idle_flush_lvl", 64'(fifo_level), 64'h2);
    cycle(0, 0, 0, 1);
    check("s_idle_flush", pkt_flit_out, 64'h00000000_00000007);
    check("s_idle_flush_h", 64'(pkt_half_out), 64'h1);
    cycle(0, 0, 0, 1);

    // Overfill with ready low, then drain in order.
    for (int i = 0; i < 2 * D + 4; i++) cycle(1, 32'h100 + 32'(i), 0, 0);
    check("s_full_lvl", 64'(fifo_level), 64'(D));
    check("s_full_ovf", 64'(overflow_count), OvfEn ? 64'd2 : 64'd0);
    for (int i = 0; i < D + 2; i++) cycle(0, 0, 0, 1);

    // Full FIFO: pair completes in the same cycle as a pop.
    for (int i = 0; i < 2 * D; i++) cycle(1, 32'h200 + 32'(i), 0, 0);
    cycle(1, 32'h300, 0, 0);
    cycle(1, 32'h301, 0, 1);
    check("s_fullpop_lvl", 64'(fifo_level), 64'(D));
    check("s_fullpop_ovf", 64'(overflow_count), OvfEn ? 64'd2 : 64'd0);
    for (int i = 0; i < D + 1; i++) cycle(0, 0, 0, 1);

    // Reset while holding a result with flits queued.
    for (int i = 0; i < 7; i++) cycle(1, 32'h400 + 32'(i), 0, 0);
    check("s_rst_pre", 64'(fifo_level), 64'h3);
    do_reset();
    check("s_rst_valid", 64'(pkt_valid_out), 64'h0);
    cycle(1, 32'h1, 0, 0);
    cycle(1, 32'h2, 0, 0);
    check("s_rst_pair", pkt_flit_out, 64'h00000002_00000001);
    cycle(0, 0, 0, 1);

    // Randomized traffic, with bursts of low ready to exercise overflow.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 7) == 0),
            (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
